io_mmio_responder: RTL and testbench

- Memory-mapped bus responder for the processor's data-memory port; the processor-facing end of the board I/O path.
- Owns the debounced switch inputs, the LED output register, sticky switch-change flags and an interrupt line.
- The processor issues single-cycle load/store accesses. This block decodes its address window and either returns read data combinationally or captures writes on the clock edge.
- Instantiated in top beside data memory; top's read mux selects this block's mem_rdata when hit=1.

---
 rtl/io_mmio_responder.sv | 174 +++++++++++++++++
 tb/tb_io_mmio_responder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_mmio_responder.sv
// io_mmio_responder
//
// Processor-facing MMIO responder for the board I/O path. Decodes a 32-byte
// register window on the data-memory port. It returns load data
// combinationally and captures stores on the rising clock edge. It owns the
// debounced switch state, sticky switch-change flags, the LED register and
// the interrupt line.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   mem_we     store strobe
//   mem_addr   byte address (decode on [31:5], register select on [4:2])
//   mem_wdata  store data
//   mem_rdata  load data, combinational, zero when hit=0
//   hit        address falls inside the register window, combinational
//   switches   raw asynchronous switch levels
//   leds       LED drive, straight from the LED register
//   irq        OR of enabled pending switch-change flags
//
// Access protocol: there is no valid/ready handshake. Every cycle is an
// access. A load is the combinational pair (mem_addr -> hit, mem_rdata)
// and has no side effects. A store is mem_we=1 with hit=1, sampled at the
// rising edge, and it always completes in that cycle.
//
// Register map (offset: access, function):
//   0x00 RO   SW_STATE  debounced switches
//   0x04 W1C  SW_EDGE   sticky change flags (set beats clear in one cycle)
//   0x08 RW   LED
//   0x0C WO   LED_SET   LED |= wdata
//   0x10 WO   LED_CLR   LED &= ~wdata
//   0x14 WO   LED_TOG   LED ^= wdata
//   0x18 RW   IRQ_EN    per-switch interrupt enable
//   0x1C RO   STATUS    bit0 = |SW_EDGE, bit1 = irq

module io_mmio_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0400,
  parameter int          NUM_SW          = 10,
  parameter int          NUM_LED         = 10,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_we,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               hit,
  input  logic [NUM_SW-1:0]  switches,
  output logic [NUM_LED-1:0] leds,
  output logic               irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] OFF_SW_STATE = 3'd0;
  localparam logic [2:0] OFF_SW_EDGE  = 3'd1;
  localparam logic [2:0] OFF_LED      = 3'd2;
  localparam logic [2:0] OFF_LED_SET  = 3'd3;
  localparam logic [2:0] OFF_LED_CLR  = 3'd4;
  localparam logic [2:0] OFF_LED_TOG  = 3'd5;
  localparam logic [2:0] OFF_IRQ_EN   = 3'd6;
  localparam logic [2:0] OFF_STATUS   = 3'd7;

  // State
  logic [NUM_SW-1:0]  sync1;
  logic [NUM_SW-1:0]  sync2;
  logic [NUM_SW-1:0]  stable;
  logic [CNT_W-1:0]   cnt [NUM_SW];
  logic [NUM_SW-1:0]  sw_edge;
  logic [NUM_SW-1:0]  irq_en;
  logic [NUM_LED-1:0] led;

  // Combinational
  logic [2:0]         off;
  logic               wr;
  logic [NUM_SW-1:0]  mismatch;
  logic [NUM_SW-1:0]  accept;
  logic [NUM_SW-1:0]  sw_edge_clr;
  logic [NUM_SW-1:0]  sw_edge_next;
  logic [NUM_SW-1:0]  irq_en_next;
  logic [NUM_LED-1:0] led_next;
  logic               unused_bits;

  // Byte lanes [1:0] and wdata bits above the register widths are ignored.
  assign unused_bits = ^{mem_addr[1:0], mem_wdata};

  // Address decode
  always_comb begin
    hit = (mem_addr[31:5] == BASE_ADDR[31:5]);
    off = mem_addr[4:2];
    wr  = mem_we && hit;
  end

  // Debounce decision. A switch commits its synchronized level only after
  // DEBOUNCE_CYCLES consecutive cycles of disagreement with the stable value.
  always_comb begin
    mismatch = sync2 ^ stable;
    accept   = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      accept[i] = mismatch[i] && (cnt[i] == CNT_LAST);
    end
  end

  // Register write decode. A new debounced change is ORed in after the W1C
  // mask, so the set wins over a clear of the same bit in the same cycle.
  always_comb begin
    sw_edge_clr = '0;
    irq_en_next = irq_en;
    led_next    = led;
    if (wr) begin
      case (off)
        OFF_SW_EDGE: sw_edge_clr = mem_wdata[NUM_SW-1:0];
        OFF_LED:     led_next    = mem_wdata[NUM_LED-1:0];
        OFF_LED_SET: led_next    = led | mem_wdata[NUM_LED-1:0];
        OFF_LED_CLR: led_next    = led & ~mem_wdata[NUM_LED-1:0];
        OFF_LED_TOG: led_next    = led ^ mem_wdata[NUM_LED-1:0];
        OFF_IRQ_EN:  irq_en_next = mem_wdata[NUM_SW-1:0];
        default:     ;
      endcase
    end
    sw_edge_next = (sw_edge & ~sw_edge_clr) | accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      stable  <= '0;
      sw_edge <= '0;
      irq_en  <= '0;
      led     <= '0;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= switches;
      sync2   <= sync1;
      stable  <= stable ^ accept;
      sw_edge <= sw_edge_next;
      irq_en  <= irq_en_next;
      led     <= led_next;
      // Any cycle of agreement restarts the count, so bounces never commit.
      for (int i = 0; i < NUM_SW; i++) begin
        if (!mismatch[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Both operands are flops, so the interrupt has no decode glitches.
  assign irq  = |(sw_edge & irq_en);
  assign leds = led;

  // Load data
  always_comb begin
    mem_rdata = '0;
    if (hit) begin
      case (off)
        OFF_SW_STATE: mem_rdata[NUM_SW-1:0]  = stable;
        OFF_SW_EDGE:  mem_rdata[NUM_SW-1:0]  = sw_edge;
        OFF_LED:      mem_rdata[NUM_LED-1:0] = led;
        OFF_IRQ_EN:   mem_rdata[NUM_SW-1:0]  = irq_en;
        OFF_STATUS:   mem_rdata[1:0]         = {irq, |sw_edge};
        default:      mem_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_mmio_responder.sv
// tb_io_mmio_responder
//
// Directed bench for io_mmio_responder with default parameters
// (BASE 0x400, 10 switches, 10 LEDs, DEBOUNCE_CYCLES = 4).
// Inputs change 1 ns after a rising edge and outputs are sampled in that
// same window, well away from the next edge.

module tb_io_mmio_responder;

  localparam logic [31:0] BASE = 32'h0000_0400;

  localparam logic [31:0] A_SW_STATE = BASE + 32'h00;
  localparam logic [31:0] A_SW_EDGE  = BASE + 32'h04;
  localparam logic [31:0] A_LED      = BASE + 32'h08;
  localparam logic [31:0] A_LED_SET  = BASE + 32'h0C;
  localparam logic [31:0] A_LED_CLR  = BASE + 32'h10;
  localparam logic [31:0] A_LED_TOG  = BASE + 32'h14;
  localparam logic [31:0] A_IRQ_EN   = BASE + 32'h18;
  localparam logic [31:0] A_STATUS   = BASE + 32'h1C;

  logic        clk;
  logic        reset;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        hit;
  logic [9:0]  switches;
  logic [9:0]  leds;
  logic        irq;

  int tests_run;
  int tests_failed;

  logic [9:0] exp_q[$];

  io_mmio_responder dut (
    .clk       (clk),
    .reset     (reset),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .hit       (hit),
    .switches  (switches),
    .leds      (leds),
    .irq       (irq)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    mem_addr  = addr;
    mem_wdata = data;
    mem_we    = 1'b1;
    tick();
    mem_we    = 1'b0;
    mem_wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    mem_we   = 1'b0;
    mem_addr = addr;
    #1;
    data = mem_rdata;
  endtask

  // Tests
  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp;
    switches = 10'd4;
    reset    = 1'b1;
    tick();
    tick();
    tests_run++;
    if (leds !== 10'd0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: leds=%h irq=%b, expected leds=000 irq=0", leds, irq);
    end
    reset = 1'b0;
    bus_read(A_SW_STATE, rd);
    tests_run++;
    if (rd !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_sw_state: got %h expected 0", rd);
    end
    // Switches held through reset commit on the 6th edge after release.
    for (int k = 1; k <= 6; k++) begin
      tick();
      bus_read(A_SW_STATE, rd);
      exp = (k == 6) ? 32'd4 : 32'd0;
      tests_run++;
      if (rd !== exp) begin
        tests_failed++;
        $display("FAIL release_sw_state_edge%0d: got %h expected %h", k, rd, exp);
      end
    end
    bus_read(A_SW_EDGE, rd);
    tests_run++;
    if (rd !== 32'd4) begin
      tests_failed++;
      $display("FAIL release_sw_edge: got %h expected 4", rd);
    end
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== 32'd1 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_status: status=%h irq=%b expected status=1 irq=0", rd, irq);
    end
  endtask

  task automatic test_led();
    logic [31:0] rd;
    logic [9:0]  exp;
    exp_q.push_back(10'h3FF);
    exp_q.push_back(10'h3F0);
    exp_q.push_back(10'h1F1);
    bus_write(A_LED, 32'h3FF);
    exp = exp_q.pop_front();
    tests_run++;
    if (leds !== exp) begin
      tests_failed++;
      $display("FAIL led_write: leds=%h expected %h", leds, exp);
    end
    bus_write(A_LED_CLR, 32'h00F);
    exp = exp_q.pop_front();
    tests_run++;
    if (leds !== exp) begin
      tests_failed++;
      $display("FAIL led_clr: leds=%h expected %h", leds, exp);
    end
    bus_write(A_LED_TOG, 32'h201);
    exp = exp_q.pop_front();
    tests_run++;
    if (leds !== exp) begin
      tests_failed++;
      $display("FAIL led_tog: leds=%h expected %h", leds, exp);
    end
    bus_write(A_LED_SET, 32'h00E);
    tests_run++;
    if (leds !== 10'h1FF) begin
      tests_failed++;
      $display("FAIL led_set: leds=%h expected 1ff", leds);
    end
    bus_write(A_LED_CLR, 32'h00E);
    bus_read(A_LED, rd);
    tests_run++;
    if (rd !== 32'h1F1) begin
      tests_failed++;
      $display("FAIL led_read: got %h expected 1f1", rd);
    end
    bus_read(A_LED_SET, rd);
    tests_run++;
    if (rd !== 32'd0 || hit !== 1'b1) begin
      tests_failed++;
      $display("FAIL wo_read: rdata=%h hit=%b expected rdata=0 hit=1", rd, hit);
    end
  endtask

  task automatic test_bounce();
    logic [31:0] rd;
    logic [31:0] exp;
    bus_write(A_SW_EDGE, 32'h004);
    bus_read(A_SW_EDGE, rd);
    tests_run++;
    if (rd !== 32'd0) begin
      tests_failed++;
      $display("FAIL w1c_clear: got %h expected 0", rd);
    end
    // Bit0 bounces with a 2-cycle half period: never 4 cycles of disagreement.
    for (int k = 0; k < 10; k++) begin
      switches[0] = ~switches[0];
      tick();
      tick();
      bus_read(A_SW_STATE, rd);
      tests_run++;
      if (rd !== 32'd4) begin
        tests_failed++;
        $display("FAIL bounce_sw_state_%0d: got %h expected 4", k, rd);
      end
    end
    bus_read(A_SW_EDGE, rd);
    tests_run++;
    if (rd !== 32'd0) begin
      tests_failed++;
      $display("FAIL bounce_no_edge: got %h expected 0", rd);
    end
    switches[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      bus_read(A_SW_STATE, rd);
      exp = (k == 6) ? 32'd5 : 32'd4;
      tests_run++;
      if (rd !== exp) begin
        tests_failed++;
        $display("FAIL settle_sw_state_edge%0d: got %h expected %h", k, rd, exp);
      end
    end
    bus_read(A_SW_EDGE, rd);
    tests_run++;
    if (rd !== 32'd1) begin
      tests_failed++;
      $display("FAIL settle_sw_edge: got %h expected 1", rd);
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    bus_write(A_SW_EDGE, 32'h001);
    bus_write(A_IRQ_EN, 32'h004);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_idle: irq=%b expected 0", irq);
    end
    // Bit2 falls: flag bit2 set after 6 edges.
    switches = 10'h001;
    for (int k = 0; k < 6; k++) tick();
    bus_read(A_STATUS, rd);
    tests_run++;
    if (irq !== 1'b1 || rd !== 32'd3) begin
      tests_failed++;
      $display("FAIL irq_raise: irq=%b status=%h expected irq=1 status=3", irq, rd);
    end
    // Bit2 rises again; clear lands on the same edge as the new commit.
    switches = 10'h005;
    for (int k = 0; k < 5; k++) tick();
    bus_write(A_SW_EDGE, 32'h004);
    bus_read(A_SW_EDGE, rd);
    tests_run++;
    if (rd !== 32'd4 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL set_beats_clear: sw_edge=%h irq=%b expected sw_edge=4 irq=1", rd, irq);
    end
    bus_read(A_SW_STATE, rd);
    tests_run++;
    if (rd !== 32'd5) begin
      tests_failed++;
      $display("FAIL set_clear_sw_state: got %h expected 5", rd);
    end
    bus_write(A_SW_EDGE, 32'h004);
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== 32'd0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL quiet_clear: status=%h irq=%b expected status=0 irq=0", rd, irq);
    end
    bus_read(A_IRQ_EN, rd);
    tests_run++;
    if (rd !== 32'd4) begin
      tests_failed++;
      $display("FAIL irq_en_read: got %h expected 4", rd);
    end
  endtask

  task automatic test_miss();
    logic [31:0] rd;
    logic [31:0] bad_addr [2];
    bad_addr[0] = BASE + 32'h20;
    bad_addr[1] = BASE - 32'h4;
    for (int k = 0; k < 2; k++) begin
      mem_addr  = bad_addr[k];
      mem_wdata = 32'hFFF;
      mem_we    = 1'b1;
      #1;
      tests_run++;
      if (hit !== 1'b0 || mem_rdata !== 32'd0) begin
        tests_failed++;
        $display("FAIL miss_decode_%0d: hit=%b rdata=%h expected hit=0 rdata=0", k, hit, mem_rdata);
      end
      tick();
      mem_we = 1'b0;
    end
    tests_run++;
    if (leds !== 10'h1F1 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL miss_leds: leds=%h irq=%b expected leds=1f1 irq=0", leds, irq);
    end
    bus_read(A_IRQ_EN, rd);
    tests_run++;
    if (rd !== 32'd4) begin
      tests_failed++;
      $display("FAIL miss_irq_en: got %h expected 4", rd);
    end
    bus_read(A_SW_EDGE, rd);
    tests_run++;
    if (rd !== 32'd0) begin
      tests_failed++;
      $display("FAIL miss_sw_edge: got %h expected 0", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic [31:0] exp;
    // Commit a bit2 fall so SW_EDGE is nonzero going into reset.
    switches = 10'h001;
    for (int k = 0; k < 6; k++) tick();
    bus_read(A_SW_EDGE, rd);
    tests_run++;
    if (rd !== 32'd4) begin
      tests_failed++;
      $display("FAIL pre_reset_edge: got %h expected 4", rd);
    end
    // Bit2 rises; four edges later its counter holds 2.
    switches = 10'h005;
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    tick();
    tests_run++;
    if (leds !== 10'd0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: leds=%h irq=%b expected 0/0", leds, irq);
    end
    bus_read(A_SW_EDGE, rd);
    tests_run++;
    if (rd !== 32'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_sw_edge: got %h expected 0", rd);
    end
    bus_read(A_IRQ_EN, rd);
    tests_run++;
    if (rd !== 32'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_irq_en: got %h expected 0", rd);
    end
    bus_read(A_SW_STATE, rd);
    tests_run++;
    if (rd !== 32'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_sw_state: got %h expected 0", rd);
    end
    reset = 1'b0;
    // The pending change is gone; the held level re-runs the full debounce.
    for (int k = 1; k <= 6; k++) begin
      tick();
      bus_read(A_SW_STATE, rd);
      exp = (k == 6) ? 32'd5 : 32'd0;
      tests_run++;
      if (rd !== exp) begin
        tests_failed++;
        $display("FAIL post_reset_sw_state_edge%0d: got %h expected %h", k, rd, exp);
      end
    end
    bus_read(A_SW_EDGE, rd);
    tests_run++;
    if (rd !== 32'd5 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_edge: sw_edge=%h irq=%b expected sw_edge=5 irq=0", rd, irq);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    switches     = '0;

    test_reset();
    test_led();
    test_bounce();
    test_irq();
    test_miss();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
